// File: rtl/pc_next_gen.sv
// Fetch PC generator: fixed-priority redirects, stall, alignment fault.
// Define PC_REDIRECT_CNT_EN to add the saturating redirectCount output.
module pc_next_gen #(
  parameter int XLEN = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter int IALIGN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            fetchReady,
  input  logic            stall,
  input  logic            trap,
  input  logic [XLEN-1:0] trapVector,
  input  logic            jumpReg,
  input  logic [XLEN-1:0] jumpRegTarget,
  input  logic            branchTaken,
  input  logic [XLEN-1:0] branchTarget,
  input  logic            jump,
  input  logic [XLEN-1:0] jumpTarget,
`ifdef PC_REDIRECT_CNT_EN
  output logic [31:0]     redirectCount,
`endif
  output logic [XLEN-1:0] pcOut,
  output logic            pcValid,
  output logic            redirected,
  output logic            misaligned
);

  typedef enum logic [1:0] {
    BOOT,
    RUN,
    FAULT
  } state_t;

  localparam logic [XLEN-1:0] INC =
    (IALIGN == 16) ? XLEN'(2) : XLEN'(4);
  localparam logic [XLEN-1:0] LOW = INC - XLEN'(1);

  state_t          state;
  logic [XLEN-1:0] tgt;
  logic            any_redir;
  logic            bad;
  logic            take;

  always_comb begin
    any_redir = trap | jumpReg | branchTaken | jump;
    tgt = jumpTarget;
    if (trap)
      tgt = trapVector & ~LOW;
    else if (jumpReg)
      tgt = {jumpRegTarget[XLEN-1:1], 1'b0};
    else if (branchTaken)
      tgt = branchTarget;
    bad = !trap && (|(tgt & LOW));
    take = 1'b0;
    case (state)
      BOOT:    take = trap;
      RUN:     take = any_redir && !bad;
      FAULT:   take = trap;
      default: take = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= BOOT;
      pcOut      <= RESET_VECTOR;
      pcValid    <= 1'b0;
      redirected <= 1'b0;
      misaligned <= 1'b0;
    end else begin
      case (state)
        BOOT: begin
          state      <= RUN;
          pcValid    <= 1'b1;
          redirected <= trap;
          if (trap)
            pcOut <= tgt;
        end
        RUN: begin
          if (any_redir) begin
            if (bad) begin
              state      <= FAULT;
              pcValid    <= 1'b0;
              misaligned <= 1'b1;
              redirected <= 1'b0;
            end else begin
              pcOut      <= tgt;
              redirected <= 1'b1;
            end
          end else if (pcValid && fetchReady && !stall) begin
            pcOut      <= pcOut + INC;
            redirected <= 1'b0;
          end
        end
        FAULT: begin
          if (trap) begin
            state      <= RUN;
            pcOut      <= tgt;
            pcValid    <= 1'b1;
            misaligned <= 1'b0;
            redirected <= 1'b1;
          end
        end
        default: begin
          state   <= BOOT;
          pcValid <= 1'b0;
        end
      endcase
    end
  end

`ifdef PC_REDIRECT_CNT_EN
  always_ff @(posedge clk) begin
    if (rst)
      redirectCount <= '0;
    else if (take && redirectCount != 32'hFFFF_FFFF)
      redirectCount <= redirectCount + 32'd1;
  end
`endif

endmodule

// File: tb/tb_pc_next_gen.sv
// Bench for pc_next_gen: directed scenarios plus randomized run
// against a behavioural model, on IALIGN=32 and IALIGN=16 instances.
module tb_pc_next_gen;

  localparam logic [31:0] RV = 32'h100;

  logic        clk = 1'b0;
  logic        rst;
  logic        fetchReady, stall, trap, jumpReg, branchTaken, jump;
  logic [31:0] trapVector, jumpRegTarget, branchTarget, jumpTarget;

  logic [31:0] pc32, pc16;
  logic        val32, val16, red32, red16, mis32, mis16;
`ifdef PC_REDIRECT_CNT_EN
  logic [31:0] cnt32, cnt16;
`endif

  int tests = 0;
  int fails = 0;

  // model state, index 0 = IALIGN 32, index 1 = IALIGN 16
  logic [31:0] m_pc[2];
  bit          m_boot[2];
  bit          m_fault[2];
  bit          m_redir[2];
  logic [31:0] m_cnt[2];

  always #5 clk = ~clk;

  pc_next_gen #(.XLEN(32), .RESET_VECTOR(RV), .IALIGN(32)) u32 (
    .clk(clk), .rst(rst), .fetchReady(fetchReady), .stall(stall),
    .trap(trap), .trapVector(trapVector),
    .jumpReg(jumpReg), .jumpRegTarget(jumpRegTarget),
    .branchTaken(branchTaken), .branchTarget(branchTarget),
    .jump(jump), .jumpTarget(jumpTarget),
`ifdef PC_REDIRECT_CNT_EN
    .redirectCount(cnt32),
`endif
    .pcOut(pc32), .pcValid(val32), .redirected(red32),
    .misaligned(mis32)
  );

  pc_next_gen #(.XLEN(32), .RESET_VECTOR(RV), .IALIGN(16)) u16 (
    .clk(clk), .rst(rst), .fetchReady(fetchReady), .stall(stall),
    .trap(trap), .trapVector(trapVector),
    .jumpReg(jumpReg), .jumpRegTarget(jumpRegTarget),
    .branchTaken(branchTaken), .branchTarget(branchTarget),
    .jump(jump), .jumpTarget(jumpTarget),
`ifdef PC_REDIRECT_CNT_EN
    .redirectCount(cnt16),
`endif
    .pcOut(pc16), .pcValid(val16), .redirected(red16),
    .misaligned(mis16)
  );

  function automatic void model_step(int k);
    int unsigned al = (k == 0) ? 4 : 2;
    logic [31:0] t;
    bit any = trap | jumpReg | branchTaken | jump;
    if (rst) begin
      m_pc[k] = RV; m_boot[k] = 1; m_fault[k] = 0;
      m_redir[k] = 0; m_cnt[k] = 0;
      return;
    end
    if (trap) t = trapVector - (trapVector % al);
    else if (jumpReg) t = jumpRegTarget - (jumpRegTarget % 2);
    else if (branchTaken) t = branchTarget;
    else t = jumpTarget;
    if (m_boot[k]) begin
      m_boot[k] = 0;
      m_redir[k] = trap;
      if (trap) begin
        m_pc[k] = t;
        if (m_cnt[k] != '1) m_cnt[k]++;
      end
    end else if (m_fault[k]) begin
      m_redir[k] = 0;
      if (trap) begin
        m_fault[k] = 0; m_pc[k] = t; m_redir[k] = 1;
        if (m_cnt[k] != '1) m_cnt[k]++;
      end
    end else if (any) begin
      if (!trap && (t % al) != 0) begin
        m_fault[k] = 1; m_redir[k] = 0;
      end else begin
        m_pc[k] = t; m_redir[k] = 1;
        if (m_cnt[k] != '1) m_cnt[k]++;
      end
    end else if (fetchReady && !stall) begin
      m_pc[k] = m_pc[k] + al; m_redir[k] = 0;
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    model_step(0);
    model_step(1);
    #1;
  endtask

  task automatic idle();
    trap = 0; jumpReg = 0; branchTaken = 0; jump = 0;
    stall = 0; fetchReady = 1;
    trapVector = 0; jumpRegTarget = 0;
    branchTarget = 0; jumpTarget = 0;
  endtask

  task automatic test_reset();
    logic [31:0] exp_seq[3] = '{32'h100, 32'h104, 32'h108};
    idle();
    rst = 1;
    tick();
    rst = 0;
    tests++;
    if (pc32 !== RV || val32 !== 0 || red32 !== 0 || mis32 !== 0) begin
      fails++;
      $display("FAIL reset: pc=%h v=%b r=%b m=%b want pc=%h v=0 r=0 m=0",
               pc32, val32, red32, mis32, RV);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      tests++;
      if (pc32 !== exp_seq[i] || val32 !== 1) begin
        fails++;
        $display("FAIL seq%0d: pc=%h v=%b want pc=%h v=1",
                 i, pc32, val32, exp_seq[i]);
      end
    end
  endtask

  task automatic test_priority();
    branchTaken = 1; branchTarget = 32'h200;
    jump = 1; jumpTarget = 32'h300;
    tick();
    branchTaken = 0; jump = 0;
    tests++;
    if (pc32 !== 32'h200 || red32 !== 1) begin
      fails++;
      $display("FAIL branch_over_jump: pc=%h r=%b want pc=200 r=1",
               pc32, red32);
    end
    tick();
    tests++;
    if (pc32 !== 32'h204 || red32 !== 0) begin
      fails++;
      $display("FAIL after_branch: pc=%h r=%b want pc=204 r=0",
               pc32, red32);
    end
  endtask

  task automatic test_stall();
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      tests++;
      if (pc32 !== 32'h204) begin
        fails++;
        $display("FAIL stall%0d: pc=%h want 204", i, pc32);
      end
    end
    jumpReg = 1; jumpRegTarget = 32'h401;
    tick();
    jumpReg = 0; stall = 0;
    tests++;
    if (pc32 !== 32'h400 || red32 !== 1) begin
      fails++;
      $display("FAIL jalr_in_stall: pc=%h r=%b want pc=400 r=1",
               pc32, red32);
    end
  endtask

  task automatic test_misaligned();
    jump = 1; jumpTarget = 32'h502;
    tick();
    tests++;
    if (pc32 !== 32'h400 || mis32 !== 1 || val32 !== 0) begin
      fails++;
      $display("FAIL misalign: pc=%h m=%b v=%b want pc=400 m=1 v=0",
               pc32, mis32, val32);
    end
    tests++;
    if (pc16 !== 32'h502 || red16 !== 1 || mis16 !== 0) begin
      fails++;
      $display("FAIL c_align: pc=%h r=%b m=%b want pc=502 r=1 m=0",
               pc16, red16, mis16);
    end
    jumpTarget = 32'h600;
    tick();
    jump = 0;
    tests++;
    if (pc32 !== 32'h400 || mis32 !== 1) begin
      fails++;
      $display("FAIL fault_ignore: pc=%h m=%b want pc=400 m=1",
               pc32, mis32);
    end
    trap = 1; trapVector = 32'h80;
    tick();
    trap = 0;
    tests++;
    if (pc32 !== 32'h80 || mis32 !== 0 || val32 !== 1 || red32 !== 1) begin
      fails++;
      $display("FAIL fault_exit: pc=%h m=%b v=%b r=%b want 80 0 1 1",
               pc32, mis32, val32, red32);
    end
  endtask

  task automatic test_wrap();
    trap = 1; trapVector = 32'hFFFF_FFFF;
    tick();
    trap = 0;
    tests++;
    if (pc32 !== 32'hFFFF_FFFC || pc16 !== 32'hFFFF_FFFE) begin
      fails++;
      $display("FAIL trap_mask: pc32=%h pc16=%h want FFFFFFFC FFFFFFFE",
               pc32, pc16);
    end
    tick();
    tests++;
    if (pc32 !== 32'h0 || pc16 !== 32'h0) begin
      fails++;
      $display("FAIL wrap: pc32=%h pc16=%h want 0 0", pc32, pc16);
    end
    jump = 1; jumpTarget = 32'h502;
    tick();
    jump = 0;
    tick();
    tests++;
    if (pc16 !== 32'h504 || red16 !== 0) begin
      fails++;
      $display("FAIL c_step: pc=%h r=%b want pc=504 r=0", pc16, red16);
    end
    trap = 1; trapVector = 32'h80;
    tick();
    trap = 0;
  endtask

  task automatic test_trap_boot();
    rst = 1;
    tick();
    rst = 0;
    trap = 1; trapVector = 32'h1003;
    branchTaken = 1; branchTarget = 32'h2000;
    tick();
    trap = 0; branchTaken = 0;
    tests++;
    if (pc32 !== 32'h1000 || pc16 !== 32'h1002 ||
        val32 !== 1 || red32 !== 1) begin
      fails++;
      $display("FAIL trap_boot: pc32=%h pc16=%h v=%b r=%b want 1000 1002 1 1",
               pc32, pc16, val32, red32);
    end
    rst = 1;
    tick();
    rst = 0;
    branchTaken = 1; branchTarget = 32'h2000;
    tick();
    branchTaken = 0;
    tests++;
    if (pc32 !== RV || val32 !== 1 || red32 !== 0) begin
      fails++;
      $display("FAIL boot_ignore: pc=%h v=%b r=%b want 100 1 0",
               pc32, val32, red32);
    end
  endtask

  function automatic logic [31:0] rnd_tgt();
    logic [31:0] t = $urandom;
    if ($urandom_range(0, 3) != 0) t[1:0] = 2'b00;
    return t;
  endfunction

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      rst         = ($urandom_range(0, 299) == 0);
      fetchReady  = ($urandom_range(0, 3) != 0);
      stall       = ($urandom_range(0, 4) == 0);
      trap        = ($urandom_range(0, 15) == 0);
      jumpReg     = ($urandom_range(0, 11) == 0);
      branchTaken = ($urandom_range(0, 9) == 0);
      jump        = ($urandom_range(0, 9) == 0);
      trapVector    = $urandom;
      jumpRegTarget = rnd_tgt();
      branchTarget  = rnd_tgt();
      jumpTarget    = rnd_tgt();
      tick();
      tests++;
      if (pc32 !== m_pc[0] || val32 !== !(m_boot[0] || m_fault[0]) ||
          red32 !== m_redir[0] || mis32 !== m_fault[0] ||
          pc16 !== m_pc[1] || val16 !== !(m_boot[1] || m_fault[1]) ||
          red16 !== m_redir[1] || mis16 !== m_fault[1]) begin
        fails++;
        $display("FAIL rand%0d: pc32=%h/%h r=%b/%b m=%b/%b pc16=%h/%h r=%b/%b m=%b/%b (got/want)",
                 i, pc32, m_pc[0], red32, m_redir[0], mis32, m_fault[0],
                 pc16, m_pc[1], red16, m_redir[1], mis16, m_fault[1]);
      end
`ifdef PC_REDIRECT_CNT_EN
      tests++;
      if (cnt32 !== m_cnt[0] || cnt16 !== m_cnt[1]) begin
        fails++;
        $display("FAIL rand_cnt%0d: got %0d/%0d want %0d/%0d",
                 i, cnt32, cnt16, m_cnt[0], m_cnt[1]);
      end
`endif
    end
    rst = 0;
    idle();
  endtask

  task automatic test_mid_reset();
    trap = 1; trapVector = 32'h40;
    tick();
    trap = 0;
    jump = 1; jumpTarget = 32'h3000;
    tick();
    jump = 0;
    tick();
`ifdef PC_REDIRECT_CNT_EN
    tests++;
    if (cnt32 !== m_cnt[0] || cnt32 == 0) begin
      fails++;
      $display("FAIL count: got %0d want %0d", cnt32, m_cnt[0]);
    end
`endif
    rst = 1;
    tick();
    rst = 0;
    tests++;
    if (pc32 !== RV || val32 !== 0) begin
      fails++;
      $display("FAIL mid_reset: pc=%h v=%b want 100 0", pc32, val32);
    end
`ifdef PC_REDIRECT_CNT_EN
    tests++;
    if (cnt32 !== 0 || cnt16 !== 0) begin
      fails++;
      $display("FAIL count_reset: got %0d/%0d want 0/0", cnt32, cnt16);
    end
`endif
  endtask

  initial begin
    rst = 1;
    idle();
    test_reset();
    test_priority();
    test_stall();
    test_misaligned();
    test_wrap();
    test_trap_boot();
    test_random();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
